dm_sb_arbiter: RTL and testbench

Two-master OBI arbiter placed directly downstream of the debug module's system-bus master port. It merges the CPU data port (master 0) and the debug module's system-bus master (master 1) onto one memory-side OBI port. It arbitrates round-robin, keeps the selection locked while a request waits for grant, and tracks outstanding transactions in order so each in-order response returns to the master that issued it.

---
 rtl/dm_sb_arbiter.sv | 123 ++++++++++++
 tb/tb_dm_sb_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sb_arbiter.sv
// Two-master OBI arbiter: round-robin with address-phase lock, in-order
// response routing through a small master-index FIFO.
module dm_sb_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_rvalid_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_rvalid_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    logic [MaxOutstanding-1:0] ids;
    logic [PtrW-1:0]           wr_ptr;
    logic [PtrW-1:0]           rd_ptr;
    logic [CntW-1:0]           count;
    logic [CntW-1:0]           count_next;
    logic                      last_grant;
    logic                      lock;
    logic                      lock_sel;
    logic                      full;
    logic                      sel;
    logic                      sel_req;
    logic                      hs;
    logic                      pop;
    logic                      head;

    assign full = (count == CntFull);

    // Locked selection holds the address phase stable until the grant arrives.
    always_comb begin
        sel = 1'b0;
        if (lock) begin
            sel = lock_sel;
        end else if (m0_req_i && m1_req_i) begin
            sel = ~last_grant;
        end else if (m1_req_i) begin
            sel = 1'b1;
        end
    end

    assign sel_req     = sel ? m1_req_i : m0_req_i;
    assign mem_req_o   = !full && sel_req;
    assign hs          = mem_req_o && mem_gnt_i;
    assign mem_we_o    = sel ? m1_we_i    : m0_we_i;
    assign mem_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign mem_be_o    = sel ? m1_be_i    : m0_be_i;
    assign mem_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    assign m0_gnt_o    = hs && !sel;
    assign m1_gnt_o    = hs && sel;

    assign pop         = mem_rvalid_i && (count != '0);
    assign head        = ids[rd_ptr];
    assign m0_rvalid_o = pop && !head;
    assign m1_rvalid_o = pop && head;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    always_comb begin
        count_next = count;
        case ({hs, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ids        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
            lock       <= 1'b0;
            lock_sel   <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            count <= count_next;
            err_o <= mem_rvalid_i && (count == '0);
            if (hs) begin
                ids[wr_ptr] <= sel;
                last_grant  <= sel;
                wr_ptr      <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
            end
            if (mem_req_o && !mem_gnt_i) begin
                lock     <= 1'b1;
                lock_sel <= sel;
            end else if (hs) begin
                lock <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dm_sb_arbiter.sv
// Directed bench for dm_sb_arbiter (MaxOutstanding = 2).
module tb_dm_sb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_gnt = 1'b0, mem_we, mem_rvalid = 1'b0, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    dm_sb_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .err_o(err)
    );

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Each cycle: inputs change 1ns after the rising edge, checks 5ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        tests_run++;
        if ({mem_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {mem_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err});
        end
        tests_run++;
        if (dut.count !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d required 0", dut.count);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        m1_addr = 32'h1000; m1_we = 1'b0; m1_be = 4'hF; m0_addr = 32'h2000;
        next_cycle();
        m1_req = 1'b1; mem_gnt = 1'b1;
        #5;
        tests_run++;
        if ({mem_req, m1_gnt, m0_gnt} !== 3'b110 || mem_addr !== 32'h1000 || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_grant: got req/g1/g0=%b addr=%h required 110 addr=00001000",
                     {mem_req, m1_gnt, m0_gnt}, mem_addr);
        end
        next_cycle();
        m1_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #5;
        tests_run++;
        if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL single_resp: got rv1=%b rv0=%b data=%h required 1 0 deadbeef",
                     m1_rvalid, m0_rvalid, m1_rdata);
        end
        next_cycle();
        idle_inputs();
        #5;
        tests_run++;
        if (err !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after: got err=%b rv0=%b rv1=%b required 0 0 0", err, m0_rvalid, m1_rvalid);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        m0_addr = 32'hA0; m1_addr = 32'hB0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            m0_req = (i < 4); m1_req = (i < 4); mem_gnt = 1'b1;
            mem_rvalid = (i > 0); mem_rdata = 32'h100 + i;
            #5;
            if (i < 4) begin
                tests_run++;
                if (m0_gnt !== ((i % 2) == 0) || m1_gnt !== ((i % 2) == 1) ||
                    mem_addr !== (((i % 2) == 1) ? 32'hB0 : 32'hA0)) begin
                    tests_failed++;
                    $display("FAIL contention_grant[%0d]: got g0=%b g1=%b addr=%h required master %0d",
                             i, m0_gnt, m1_gnt, mem_addr, i % 2);
                end
            end
            if (i > 0) begin
                tests_run++;
                if (m0_rvalid !== (((i - 1) % 2) == 0) || m1_rvalid !== (((i - 1) % 2) == 1) ||
                    m0_rdata !== 32'h100 + i) begin
                    tests_failed++;
                    $display("FAIL contention_resp[%0d]: got rv0=%b rv1=%b data=%h required master %0d",
                             i, m0_rvalid, m1_rvalid, m0_rdata, (i - 1) % 2);
                end
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_lock();
        apply_reset();
        m0_addr = 32'h3000; m1_addr = 32'h4000;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            m1_req = (i < 4); m0_req = (i >= 1); mem_gnt = (i >= 3);
            #5;
            if (i < 3) begin
                tests_run++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL lock_hold[%0d]: got req=%b addr=%h g0=%b g1=%b required 1 00004000 0 0",
                             i, mem_req, mem_addr, m0_gnt, m1_gnt);
                end
            end else if (i == 3) begin
                tests_run++;
                if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_addr !== 32'h4000) begin
                    tests_failed++;
                    $display("FAIL lock_release: got g1=%b g0=%b addr=%h required 1 0 00004000",
                             m1_gnt, m0_gnt, mem_addr);
                end
            end else begin
                tests_run++;
                if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_addr !== 32'h3000) begin
                    tests_failed++;
                    $display("FAIL lock_next: got g0=%b g1=%b addr=%h required 1 0 00003000",
                             m0_gnt, m1_gnt, mem_addr);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            m0_req = 1'b0; m1_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
            #5;
            tests_run++;
            if (m1_rvalid !== (i == 0) || m0_rvalid !== (i == 1)) begin
                tests_failed++;
                $display("FAIL lock_resp[%0d]: got rv0=%b rv1=%b required master %0d", i, m0_rvalid, m1_rvalid, 1 - i);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_full();
        apply_reset();
        m0_addr = 32'h5000;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            m0_req = 1'b1; mem_gnt = 1'b1;
            #5;
            tests_run++;
            if (m0_gnt !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_fill[%0d]: got g0=%b required 1", i, m0_gnt);
            end
        end
        next_cycle();
        #5;
        tests_run++;
        if (mem_req !== 1'b0 || m0_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_block: got req=%b g0=%b required 0 0", mem_req, m0_gnt);
        end
        next_cycle();
        mem_rvalid = 1'b1;
        #5;
        tests_run++;
        if (mem_req !== 1'b0 || m0_gnt !== 1'b0 || m0_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pop_same: got req=%b g0=%b rv0=%b required 0 0 1", mem_req, m0_gnt, m0_rvalid);
        end
        next_cycle();
        mem_rvalid = 1'b0;
        #5;
        tests_run++;
        if (mem_req !== 1'b1 || m0_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_reopen: got req=%b g0=%b required 1 1", mem_req, m0_gnt);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            m0_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
            #5;
            tests_run++;
            if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL full_drain[%0d]: got rv0=%b rv1=%b required 1 0", i, m0_rvalid, m1_rvalid);
            end
        end
        next_cycle();
        idle_inputs();
        #5;
        tests_run++;
        if (err !== 1'b0 || dut.count !== 2'd0) begin
            tests_failed++;
            $display("FAIL full_empty: got err=%b count=%0d required 0 0", err, dut.count);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] pat;
        pat = 10'b1101001011;
        apply_reset();
        m0_addr = 32'h6000; m1_addr = 32'h7000;
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            m0_req = (i < 10) && !pat[i % 10]; m1_req = (i < 10) && pat[i % 10];
            mem_gnt = 1'b1; mem_rvalid = (i > 0); mem_rdata = 32'hC000 + i;
            #5;
            if (i < 10) begin
                tests_run++;
                if (m1_gnt !== pat[i] || m0_gnt !== !pat[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_grant[%0d]: got g0=%b g1=%b required master %0d", i, m0_gnt, m1_gnt, pat[i]);
                end
            end
            if (i > 0) begin
                tests_run++;
                if (m1_rvalid !== pat[i - 1] || m0_rvalid !== !pat[i - 1] || dut.count !== 2'd1 ||
                    m1_rdata !== 32'hC000 + i) begin
                    tests_failed++;
                    $display("FAIL b2b_resp[%0d]: got rv0=%b rv1=%b count=%0d data=%h required master %0d count 1",
                             i, m0_rvalid, m1_rvalid, dut.count, m1_rdata, pat[i - 1]);
                end
            end
        end
        next_cycle();
        idle_inputs();
        #5;
        tests_run++;
        if (dut.count !== 2'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_empty: got count=%0d err=%b required 0 0", dut.count, err);
        end
    endtask

    task automatic test_orphan();
        apply_reset();
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        #5;
        tests_run++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL orphan_cycle: got rv0=%b rv1=%b err=%b required 0 0 0", m0_rvalid, m1_rvalid, err);
        end
        next_cycle();
        mem_rvalid = 1'b0;
        #5;
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL orphan_err: got %b required 1", err);
        end
        next_cycle();
        #5;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL orphan_err_clear: got %b required 0", err);
        end
        next_cycle();
        m0_req = 1'b1; mem_gnt = 1'b1;
        next_cycle();
        idle_inputs();
        #2;
        tests_run++;
        if (dut.count !== 2'd1) begin
            tests_failed++;
            $display("FAIL midtx_count: got %0d required 1", dut.count);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (dut.count !== 2'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got count=%0d err=%b required 0 0", dut.count, err);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        mem_rvalid = 1'b1;
        #5;
        tests_run++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stale_resp: got rv0=%b rv1=%b required 0 0", m0_rvalid, m1_rvalid);
        end
        next_cycle();
        mem_rvalid = 1'b0;
        #5;
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL stale_err: got %b required 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_full();
        test_back_to_back();
        test_orphan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
